// File: rtl/wb_regfile_pkg.sv
// Core types shared by the writeback/register-file slice.
// Register addresses, data words and writeback source encodings.
package wb_regfile_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10
  } wb_data_sel_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback inputs plus the two ID read ports of the register file.
// No handshake: every signal is sampled or produced each cycle; a bubble is reg_write_c_i=0.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  reg_addr_t    rd_i;
  data_t        alu_result_i;
  data_t        pc_next_i;
  data_t        mem_read_data_i;
  enable_t      reg_write_c_i;
  wb_data_sel_t wb_data_sel_c_i;
  reg_addr_t    rs1_i;
  reg_addr_t    rs2_i;
  data_t        rs1_data_o;
  data_t        rs2_data_o;
  data_t        wb_data_o;

  modport master (
    output rd_i, alu_result_i, pc_next_i, mem_read_data_i,
    output reg_write_c_i, wb_data_sel_c_i, rs1_i, rs2_i,
    input  rs1_data_o, rs2_data_o, wb_data_o
  );

  modport slave (
    input  rd_i, alu_result_i, pc_next_i, mem_read_data_i,
    input  reg_write_c_i, wb_data_sel_c_i, rs1_i, rs2_i,
    output rs1_data_o, rs2_data_o, wb_data_o
  );
endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Writeback source select: ALU result, load data or link address.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  wb_data_sel_t sel_i,
  input  data_t        alu_result_i,
  input  data_t        mem_read_data_i,
  input  data_t        pc_next_i,
  output data_t        wb_data_o
);

  always_comb begin
    wb_data_o = '0;
    case (sel_i)
      WB_ALU:  wb_data_o = alu_result_i;
      WB_MEM:  wb_data_o = mem_read_data_i;
      WB_PC:   wb_data_o = pc_next_i;
      default: wb_data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 integer register file with writeback mux; x0 reads as zero.
// Define WB_BYPASS_EN for write-first reads of the register being written this cycle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  data_t           wb_data;
  data_t           rs1_d;
  data_t           rs2_d;
  logic            wr_en;

  wb_mux u_wb_mux (
    .sel_i           (bus.wb_data_sel_c_i),
    .alu_result_i    (bus.alu_result_i),
    .mem_read_data_i (bus.mem_read_data_i),
    .pc_next_i       (bus.pc_next_i),
    .wb_data_o       (wb_data)
  );

  assign wr_en = bus.reg_write_c_i && (bus.rd_i != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.rd_i] <= wb_data;
    end
  end

  // Bypass is gated by rst_n so both ports read zero for the whole reset.
  always_comb begin
    rs1_d = (bus.rs1_i == REG_ZERO) ? '0 : regs_q[bus.rs1_i];
    rs2_d = (bus.rs2_i == REG_ZERO) ? '0 : regs_q[bus.rs2_i];
`ifdef WB_BYPASS_EN
    if (rst_n && wr_en && (bus.rs1_i == bus.rd_i)) rs1_d = wb_data;
    if (rst_n && wr_en && (bus.rs2_i == bus.rd_i)) rs2_d = wb_data;
`else
`endif
  end

  assign bus.rs1_data_o = rs1_d;
  assign bus.rs2_data_o = rs2_d;
  assign bus.wb_data_o  = wb_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based model.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst_n;
  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [31:0] model [32];
  logic [95:0] exp_q [$];
  int n_vec;
  int n_err;

  function automatic logic [31:0] ref_wb(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] mem, input logic [31:0] pc);
    if (sel == 2'd0) return alu;
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return pc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit in_rst, input bit we,
                                           input logic [4:0] rd, input logic [31:0] wbv);
    if (in_rst || a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && rd != 5'd0 && a == rd) return wbv;
`endif
    return model[a];
  endfunction

  // driver
  task automatic apply(input bit rst_hold, input bit we, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] wbv;
    @(posedge clk);
    #1;
    bus.reg_write_c_i   = we;
    bus.wb_data_sel_c_i = wb_data_sel_t'(sel);
    bus.rd_i            = rd;
    bus.alu_result_i    = alu;
    bus.mem_read_data_i = mem;
    bus.pc_next_i       = pc;
    bus.rs1_i           = rs1;
    bus.rs2_i           = rs2;
    rst_n               = !rst_hold;
    if (rst_hold) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    wbv = ref_wb(sel, alu, mem, pc);
    exp_q.push_back({ref_read(rs1, rst_hold, we, rd, wbv),
                     ref_read(rs2, rst_hold, we, rd, wbv), wbv});
    if (!rst_hold && we && rd != 5'd0) model[rd] = wbv;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] v,
                    input logic [4:0] rs1, input logic [4:0] rs2);
    apply(1'b0, 1'b1, sel, rd, v, v, v, rs1, rs2);
  endtask

  task automatic rd_only(input logic [4:0] rs1, input logic [4:0] rs2);
    apply(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, rs1, rs2);
  endtask

  // monitor: one expected entry per presented cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [95:0] e;
      e = exp_q.pop_front();
      n_vec += 3;
      if (bus.rs1_data_o !== e[95:64]) begin
        n_err++;
        $display("FAIL rs1_data t=%0t rs1=%0d actual=%h required=%h", $time, bus.rs1_i, bus.rs1_data_o, e[95:64]);
      end
      if (bus.rs2_data_o !== e[63:32]) begin
        n_err++;
        $display("FAIL rs2_data t=%0t rs2=%0d actual=%h required=%h", $time, bus.rs2_i, bus.rs2_data_o, e[63:32]);
      end
      if (bus.wb_data_o !== e[31:0]) begin
        n_err++;
        $display("FAIL wb_data t=%0t sel=%0d actual=%h required=%h", $time, bus.wb_data_sel_c_i, bus.wb_data_o, e[31:0]);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n               = 1'b0;
    bus.reg_write_c_i   = 1'b0;
    bus.wb_data_sel_c_i = WB_ALU;
    bus.rd_i            = '0;
    bus.alu_result_i    = '0;
    bus.mem_read_data_i = '0;
    bus.pc_next_i       = '0;
    bus.rs1_i           = '0;
    bus.rs2_i           = '0;

    // reset state, then async clear of x5 and a write dropped under reset
    apply(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    wr(2'd0, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    rd_only(5'd5, 5'd0);
    apply(1'b1, 1'b1, 2'd0, 5'd6, 32'h66, 32'h0, 32'h0, 5'd5, 5'd6);
    rd_only(5'd5, 5'd6);

    // each writeback source
    apply(1'b0, 1'b1, 2'd0, 5'd3, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0);
    rd_only(5'd3, 5'd0);
    apply(1'b0, 1'b1, 2'd1, 5'd4, 32'h0, 32'hFFFFFF80, 32'h0, 5'd3, 5'd0);
    apply(1'b0, 1'b1, 2'd2, 5'd1, 32'h0, 32'h0, 32'h00000104, 5'd4, 5'd0);
    rd_only(5'd4, 5'd1);

    // x0 ignores writes but the mux still shows the value
    wr(2'd0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    rd_only(5'd0, 5'd0);

    // enable gating and bubble between writes
    wr(2'd0, 5'd7, 32'h77, 5'd0, 5'd0);
    apply(1'b0, 1'b0, 2'd0, 5'd7, 32'hAAAA5555, 32'h0, 32'h0, 5'd7, 5'd0);
    rd_only(5'd7, 5'd0);
    wr(2'd1, 5'd8, 32'h88, 5'd0, 5'd0);
    rd_only(5'd0, 5'd0);
    rd_only(5'd8, 5'd7);

    // same-cycle read of the write target
    wr(2'd0, 5'd9, 32'h11, 5'd0, 5'd0);
    wr(2'd0, 5'd9, 32'h22, 5'd9, 5'd9);
    rd_only(5'd9, 5'd9);

    // back-to-back writes, independent ports
    wr(2'd0, 5'd11, 32'hB, 5'd0, 5'd0);
    wr(2'd0, 5'd10, 32'h1, 5'd0, 5'd0);
    wr(2'd0, 5'd10, 32'h2, 5'd10, 5'd11);
    rd_only(5'd10, 5'd11);

    // random traffic, reads often aimed at the write target
    for (int n = 0; n < 300; n++) begin
      logic [4:0] rd_r;
      logic [4:0] a1;
      logic [4:0] a2;
      rd_r = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31));
      apply(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            rd_r, $urandom, $urandom, $urandom, a1, a2);
    end
    rd_only(5'd0, 5'd0);

    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: entries left actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. Selects the writeback value (ALU result, load data, or PC+4) and commits it to a 32x32 integer register file. Serves two combinational read ports to the decode stage, with optional same-cycle write-to-read bypass. Sits at the end of the 5-stage RV32I pipeline; ID reads from it and WB writes to it.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is included and hardwired to zero.
- XLEN, 32, data width; must equal the width of data_t.

Ports:
- clk  in  1  pipeline clock; writes commit on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_i  in  reg_addr_t(5)  writeback destination register, from MEM/WB.
- alu_result_i  in  data_t(32)  ALU result, from MEM/WB.
- pc_next_i  in  data_t(32)  PC+4 for JAL/JALR link, from MEM/WB.
- mem_read_data_i  in  data_t(32)  load data, already extended, from MEM/WB.
- reg_write_c_i  in  enable_t(1)  writeback enable.
- wb_data_sel_c_i  in  wb_data_sel_t(2)  writeback source select.
- rs1_i  in  reg_addr_t(5)  read address, port 1, from ID.
- rs2_i  in  reg_addr_t(5)  read address, port 2, from ID.
- rs1_data_o  out  data_t(32)  read data, port 1.
- rs2_data_o  out  data_t(32)  read data, port 2.
- wb_data_o  out  data_t(32)  selected writeback value; feeds the EX forwarding mux.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, registers x1..x31 are cleared to 0 asynchronously and no write occurs. Writes resume on the first rising edge after rst_n deasserts.
- Reset mid-operation: a write presented on the edge where rst_n is low is dropped.
- Writeback mux (combinational), driving wb_data_o:
  - WB_ALU: alu_result_i.
  - WB_MEM: mem_read_data_i.
  - WB_PC: pc_next_i.
  - Reserved encoding: 0, no X propagation.
- Write: on posedge clk with rst_n=1, reg_write_c_i=1 and rd_i!=0, regs[rd_i] <= wb_data_o. Write latency is one edge. With rd_i=0 the write is ignored.
- Reads: combinational. rsN_data_o = 0 when rsN_i=0, otherwise regs[rsN_i]. Outputs are valid during reset as 0.
- Simultaneous read and write of the same register:
  - With bypass enabled, the read returns the value being written.
  - With bypass disabled, the read returns the old value.
- Both read ports may address the same register, including the write target; each port resolves independently.
- Back-to-back writes to the same rd: the last write wins, one per cycle.
- The module has no stall or flush input. Bubbles arrive as reg_write_c_i=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if reg_write_c_i=1, rd_i!=0 and rsN_i==rd_i, then rsN_data_o = wb_data_o in the same cycle (write-first). This removes the WB->ID hazard.
- Undefined: reads return the stored array value only, so the hazard unit must stall one extra cycle for WB->ID dependencies. Write behaviour is identical in both builds.

Decomposition:
- Shared package (existing core types package) holds:
  - reg_addr_t (logic[4:0]), data_t (logic[31:0]), enable_t (logic).
  - wb_data_sel_t enum: WB_ALU=2'b00, WB_MEM=2'b01, WB_PC=2'b10.
  - Constant REG_ZERO=5'd0.
- Sub-module wb_mux, purely combinational, instantiated once. Storage, write logic and read/bypass logic stay in the top-level module.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse rst_n low mid-cycle with no clock edge → reading x5 returns 0 immediately. A write presented while rst_n=0 has no effect.
- Mux and write sources:
  - sel=WB_ALU, alu=0x12345678, rd=3, we=1 → after the edge, rs1=3 reads 0x12345678.
  - sel=WB_MEM, mem=0xFFFFFF80, rd=4 → x4=0xFFFFFF80.
  - sel=WB_PC, pc_next=0x00000104, rd=1 → x1=0x104.
- x0: write rd=0 with data 0xFFFFFFFF → rs1=0 and rs2=0 read 0, and wb_data_o=0xFFFFFFFF.
- Write-enable gating: we=0, rd=7, data 0xAAAA5555 → x7 is unchanged. A bubble between two writes preserves the first value.
- Same-cycle hazard: x9=0x11 stored, then write rd=9 data 0x22 with rs1=rs2=9 in the same cycle → both ports read 0x22 with WB_BYPASS_EN defined, 0x11 without. After the edge, both builds read 0x22.
- Back-to-back writes: rd=10 gets 0x1 then 0x2 on consecutive edges → reads 0x2; rs1=10 and rs2=11 return independent values.
